router_pkt_source: RTL and testbench
====================================

Name: router_pkt_source

Overview:
- Parametrised source-port engine for the 1xN router.
- Accepts payload beats on an upstream valid/ready stream and buffers one whole packet.
- Emits the router frame (header, payload, parity) on data_in/pkt_valid, honouring busy backpressure.
- Watches error after each packet and retransmits from its buffer up to MAX_RETRY times. Replaces a fixed 8-bit, 3-port, no-retry source.

Parameters:
- DATA_W, 8: router byte width; header, payload and parity are all DATA_W.
- ADDR_W, 2: destination field width; the router has up to 2^ADDR_W ports.
- MAX_LEN, 63: maximum payload beats. Must be ≤ 2^(DATA_W-ADDR_W)-1.
- MAX_RETRY, 2: retransmissions after an error before the packet is abandoned.
- ERR_WIN, 3: cycles after the parity transfer during which error is sampled.

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream beat accepted when s_valid & s_ready
- s_data  in  DATA_W  payload beat
- s_last  in  1  final beat of packet
- s_dest  in  ADDR_W  destination, sampled on the first beat only
- data_in  out  DATA_W  byte to router
- pkt_valid  out  1  frame valid (header/payload)
- busy  in  1  router stall
- error  in  1  router parity error
- tx_done  out  1  one-cycle pulse, packet delivered without error
- tx_fail  out  1  one-cycle pulse, packet abandoned after MAX_RETRY
- trunc  out  1  one-cycle pulse, packet exceeded MAX_LEN
- err_count  out  16  saturating count of error events seen

Behaviour:
- Reset (one clk with reset=1):
  - State goes to IDLE.
  - s_ready=0, data_in=0, pkt_valid=0, all pulses 0, err_count=0, retry count 0, buffer pointers 0.
  - Reset mid-frame drops the packet; pkt_valid is 0 the cycle after reset.
- States: IDLE, LOAD, DROP, HDR, PAY, PAR, ECHK.
- IDLE: s_ready=1.
  - First accepted beat writes buffer[0], latches s_dest, len=1, running parity = s_data.
  - Next state is HDR if s_last, else LOAD.
- LOAD: s_ready=1; each accepted beat writes buffer[len], len+=1, XORs into parity.
  - Accepted s_last goes to HDR.
  - Beat that makes len==MAX_LEN without s_last: pulse trunc, go to DROP.
- DROP: s_ready=1; beats are discarded until an accepted s_last, then go to HDR with len=MAX_LEN.
- s_ready=0 in HDR, PAY, PAR, ECHK (one packet in flight).
- Header byte: {len[DATA_W-ADDR_W-1:0], dest}. Parity = header XOR all payload bytes.
- Transfer rule: a byte transfers on a clk where busy=0. While busy=1, data_in and pkt_valid hold their values unchanged.
- HDR: data_in=header, pkt_valid=1; on transfer go to PAY, rd_ptr=0.
- PAY: data_in=buffer[rd_ptr], pkt_valid=1; on transfer rd_ptr+=1. Transfer of beat len-1 goes to PAR.
- PAR: data_in=parity, pkt_valid=0; on transfer go to ECHK, window counter = ERR_WIN.
- ECHK: data_in=0, pkt_valid=0.
  - error=1 on any cycle of the window: err_count+=1 (saturating at 0xFFFF), leave the window immediately.
    - If retry < MAX_RETRY: retry+=1, go to HDR (replay from buffer, same header and parity).
    - Else: pulse tx_fail, go to IDLE.
  - Window expires with no error: pulse tx_done, go to IDLE.
  - retry clears on entry to IDLE.
- Pulse timing: tx_done/tx_fail assert on the cycle the state moves to IDLE; s_ready=1 the following cycle.
- Simultaneous events:
  - busy=1 in PAR postpones the error window; error is ignored outside ECHK.
  - error and window expiry on the same cycle counts as error.
- Latency: header is presented 1 cycle after the s_last acceptance. Minimum frame is len+2 transfer cycles.

Decomposition:
- Package router_pkg holds:
  - DATA_W/ADDR_W defaults.
  - State enum src_state_e.
  - Function make_header(len, dest).
  - Function parity_fold.
- Sub-module router_pkt_buf: MAX_LEN×DATA_W single-port-write/single-port-read register array with synchronous write and combinational read. Read address comes from the FSM so replay is a pointer reset.

Test Plan:
- Defaults, dest=2, beats 0x11,0x22,0x33 (last on 0x33), busy=0 -> data_in sequence:
  - 0x0E, 0x11, 0x22, 0x33 with pkt_valid=1;
  - then parity 0x0E with pkt_valid=0;
  - tx_done pulse 3 cycles after the parity transfer.
- Same packet with busy=1 for 4 cycles during payload 0x22 -> 0x22 held stable for 5 cycles, no beat skipped or duplicated, parity still 0x0E.
- error=1 one cycle after the parity transfer, every attempt -> frame replayed identically twice, err_count=3, tx_fail pulses once, no tx_done.
- error on the first attempt only -> one replay, err_count=1, tx_done pulses.
- Feed 70 beats, dest=1, last on beat 70 -> trunc pulses on beat 63, beats 64-70 dropped, header 0xFD, 63 payload bytes sent.
- reset=1 for one cycle mid-payload -> next cycle pkt_valid=0, data_in=0, err_count=0, s_ready=1; a new packet then transmits correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types, default widths and helpers for the router source-port engine.
package router_pkg;

    // Widths of the classic router: 8-bit bytes, 2-bit destination field.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    // Source engine states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,  // waiting for the first beat of a packet
        ST_LOAD = 3'd1,  // buffering payload beats
        ST_DROP = 3'd2,  // packet too long, discarding until its last beat
        ST_HDR  = 3'd3,  // presenting the header byte
        ST_PAY  = 3'd4,  // presenting payload bytes from the buffer
        ST_PAR  = 3'd5,  // presenting the parity byte
        ST_ECHK = 3'd6   // watching the error line after the frame
    } src_state_e;

    // Header byte: length in the upper bits, destination in the low ADDR_W bits.
    // Computed at a generous fixed width so any DATA_W/ADDR_W pair can use it;
    // the caller keeps the low DATA_W bits.
    function automatic logic [63:0] make_header(input logic [31:0] len,
                                                input logic [31:0] dest,
                                                input int          data_w,
                                                input int          addr_w);
        logic [63:0] len_field;
        logic [63:0] dest_field;
        len_field  = {32'b0, len}  & ((64'd1 << (data_w - addr_w)) - 64'd1);
        dest_field = {32'b0, dest} & ((64'd1 << addr_w) - 64'd1);
        return (len_field << addr_w) | dest_field;
    endfunction

    // One step of the running byte-wise XOR parity.
    function automatic logic [63:0] parity_fold(input logic [63:0] acc,
                                                input logic [63:0] beat);
        return acc ^ beat;
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Packet buffer: one write port (synchronous) and one read port (combinational).
// The read address is owned by the source FSM, so a replay is just a pointer reset.
module router_pkt_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 63,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store an accepted payload beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Present the byte at the FSM's read pointer in the same cycle.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/router_pkt_source.sv
// Source-port engine for the 1xN router: buffers one packet from an upstream
// stream, frames it as header/payload/parity, and replays it from the buffer
// when the router flags a parity error, up to MAX_RETRY times.
//
// Upstream handshake: a beat moves only on a clk edge where s_valid and s_ready
// are both 1; s_ready never depends on s_valid, and s_data/s_last/s_dest are
// only looked at on such an edge.
// Router side: a byte moves on every clk edge where busy is 0; while busy is 1
// data_in and pkt_valid hold.
module router_pkt_source
    import router_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_LEN   = 63,
    parameter int MAX_RETRY = 2,
    parameter int ERR_WIN   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [ADDR_W-1:0] s_dest,
    output logic [DATA_W-1:0] data_in,
    output logic              pkt_valid,
    input  logic              busy,
    input  logic              error,
    output logic              tx_done,
    output logic              tx_fail,
    output logic              trunc,
    output logic [15:0]       err_count
);

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int WIN_W   = $clog2(ERR_WIN + 1);

    src_state_e state;
    src_state_e state_next;

    logic [LEN_W-1:0]   len_q;
    logic [ADDR_W-1:0]  dest_q;
    logic [DATA_W-1:0]  pay_par_q;   // XOR of payload bytes only
    logic [AW-1:0]      rd_ptr_q;
    logic [RETRY_W-1:0] retry_q;
    logic [WIN_W-1:0]   win_q;
    logic [15:0]        err_count_q;

    logic               xfer;
    logic               last_beat;
    logic               len_at_cap;
    logic               retry_left;
    logic               win_last;
    logic [DATA_W-1:0]  header;
    logic [DATA_W-1:0]  parity;

    logic               buf_we;
    logic [AW-1:0]      buf_waddr;
    logic [DATA_W-1:0]  buf_rdata;

    // Shared decodes used by both the FSM and the datapath.
    always_comb begin
        xfer       = !busy;
        last_beat  = (LEN_W'(rd_ptr_q) == (len_q - LEN_W'(1)));
        len_at_cap = (len_q == LEN_W'(MAX_LEN - 1));
        retry_left = (retry_q < RETRY_W'(MAX_RETRY));
        win_last   = (win_q == WIN_W'(1));
        header     = DATA_W'(make_header(32'(len_q), 32'(dest_q), DATA_W, ADDR_W));
        parity     = DATA_W'(parity_fold(64'(header), 64'(pay_par_q)));
    end

    router_pkt_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN),
        .AW     (AW)
    ) u_buf (
        .clk    (clk),
        .we     (buf_we),
        .waddr  (buf_waddr),
        .wdata  (s_data),
        .raddr  (rd_ptr_q),
        .rdata  (buf_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    if (s_last) begin
                        state_next = ST_HDR;
                    end else if (MAX_LEN == 1) begin
                        state_next = ST_DROP;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    if (s_last) begin
                        state_next = ST_HDR;
                    end else if (len_at_cap) begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (s_valid && s_last) begin
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    state_next = ST_PAY;
                end
            end
            ST_PAY: begin
                if (xfer && last_beat) begin
                    state_next = ST_PAR;
                end
            end
            ST_PAR: begin
                if (xfer) begin
                    state_next = ST_ECHK;
                end
            end
            ST_ECHK: begin
                // An error on the final window cycle still counts as an error.
                if (error) begin
                    state_next = retry_left ? ST_HDR : ST_IDLE;
                end else if (win_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore/Mealy outputs and buffer write control.
    always_comb begin
        s_ready   = 1'b0;
        data_in   = '0;
        pkt_valid = 1'b0;
        tx_done   = 1'b0;
        tx_fail   = 1'b0;
        trunc     = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = '0;
        case (state)
            ST_IDLE: begin
                // Held low during reset so no beat is accepted and then lost.
                s_ready   = !reset;
                buf_we    = s_valid && !reset;
                buf_waddr = '0;
                trunc     = (MAX_LEN == 1) && s_valid && !s_last && !reset;
            end
            ST_LOAD: begin
                s_ready   = !reset;
                buf_we    = s_valid && !reset;
                buf_waddr = len_q[AW-1:0];
                trunc     = s_valid && !s_last && len_at_cap && !reset;
            end
            ST_DROP: begin
                s_ready   = !reset;
            end
            ST_HDR: begin
                data_in   = header;
                pkt_valid = 1'b1;
            end
            ST_PAY: begin
                data_in   = buf_rdata;
                pkt_valid = 1'b1;
            end
            ST_PAR: begin
                data_in   = parity;
            end
            ST_ECHK: begin
                tx_done   = !error && win_last;
                tx_fail   = error && !retry_left;
            end
            default: begin
                s_ready   = 1'b0;
            end
        endcase
    end

    // Datapath: packet length, destination, parity, pointers, retry and error bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            dest_q      <= '0;
            pay_par_q   <= '0;
            rd_ptr_q    <= '0;
            retry_q     <= '0;
            win_q       <= '0;
            err_count_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        len_q     <= LEN_W'(1);
                        dest_q    <= s_dest;
                        pay_par_q <= DATA_W'(parity_fold(64'd0, 64'(s_data)));
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        len_q     <= len_q + LEN_W'(1);
                        pay_par_q <= DATA_W'(parity_fold(64'(pay_par_q), 64'(s_data)));
                    end
                end
                ST_DROP: begin
                    if (s_valid && s_last) begin
                        len_q <= LEN_W'(MAX_LEN);
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        rd_ptr_q <= '0;
                    end
                end
                ST_PAY: begin
                    // Park the pointer at 0 after the last beat so a replay starts clean.
                    if (xfer) begin
                        rd_ptr_q <= last_beat ? '0 : rd_ptr_q + AW'(1);
                    end
                end
                ST_PAR: begin
                    if (xfer) begin
                        win_q <= WIN_W'(ERR_WIN);
                    end
                end
                ST_ECHK: begin
                    win_q <= win_q - WIN_W'(1);
                    if (error) begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_q <= err_count_q + 16'd1;
                        end
                        if (retry_left) begin
                            retry_q <= retry_q + RETRY_W'(1);
                        end
                    end
                    if (state_next == ST_IDLE) begin
                        retry_q <= '0;
                    end
                end
                default: begin
                    len_q <= len_q;
                end
            endcase
        end
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_router_pkt_source.sv
// Directed bench for router_pkt_source: framing, busy stalls, retries,
// truncation and mid-frame reset, with hand-computed expected bytes.
module tb_router_pkt_source;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [1:0]  s_dest;
    logic [7:0]  data_in;
    logic        pkt_valid;
    logic        busy;
    logic        error;
    logic        tx_done;
    logic        tx_fail;
    logic        trunc;
    logic [15:0] err_count;

    int tests_run    = 0;
    int tests_failed = 0;

    router_pkt_source dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_dest    (s_dest),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .busy      (busy),
        .error     (error),
        .tx_done   (tx_done),
        .tx_fail   (tx_fail),
        .trunc     (trunc),
        .err_count (err_count)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drive one upstream beat; it must be accepted in this cycle.
    task automatic put_beat(input string tag, input logic [7:0] d, input logic last,
                            input logic [1:0] dst, input logic exp_trunc);
        s_valid = 1'b1; s_data = d; s_last = last; s_dest = dst;
        #1;
        chk({tag, "_ready"}, 16'(s_ready), 16'(1'b1));
        chk({tag, "_trunc"}, 16'(trunc), 16'(exp_trunc));
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; s_dest = 2'd0;
    endtask

    // One router-side cycle with given busy/error, checking the presented byte.
    task automatic step_chk(input string tag, input logic [7:0] d, input logic v,
                            input logic b, input logic e);
        busy = b; error = e;
        #1;
        chk({tag, "_data"}, 16'(data_in), 16'(d));
        chk({tag, "_valid"}, 16'(pkt_valid), 16'(v));
        @(posedge clk); #1;
        busy = 1'b0; error = 1'b0;
    endtask

    // One cycle of the error window.
    task automatic echk_step(input string tag, input logic e, input logic exp_done,
                             input logic exp_fail);
        error = e;
        #1;
        chk({tag, "_data"}, 16'(data_in), 16'h0000);
        chk({tag, "_valid"}, 16'(pkt_valid), 16'h0000);
        chk({tag, "_done"}, 16'(tx_done), 16'(exp_done));
        chk({tag, "_fail"}, 16'(tx_fail), 16'(exp_fail));
        @(posedge clk); #1;
        error = 1'b0;
    endtask

    // Load 0x11,0x22,0x33 to dest 2.
    task automatic load3(input string tag);
        put_beat({tag, "_b0"}, 8'h11, 1'b0, 2'd2, 1'b0);
        put_beat({tag, "_b1"}, 8'h22, 1'b0, 2'd2, 1'b0);
        put_beat({tag, "_b2"}, 8'h33, 1'b1, 2'd2, 1'b0);
    endtask

    // Frame for that packet: header {3,2}=0x0E, payload, parity 0x0E^0x11^0x22^0x33=0x0E.
    task automatic frame3(input string tag);
        step_chk({tag, "_hdr"}, 8'h0E, 1'b1, 1'b0, 1'b0);
        step_chk({tag, "_p0"},  8'h11, 1'b1, 1'b0, 1'b0);
        step_chk({tag, "_p1"},  8'h22, 1'b1, 1'b0, 1'b0);
        step_chk({tag, "_p2"},  8'h33, 1'b1, 1'b0, 1'b0);
        step_chk({tag, "_par"}, 8'h0E, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        s_dest = 2'd0; busy = 1'b0; error = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Reset state.
        #1;
        chk("rst_ready", 16'(s_ready), 16'h0001);
        chk("rst_data", 16'(data_in), 16'h0000);
        chk("rst_valid", 16'(pkt_valid), 16'h0000);
        chk("rst_errcnt", err_count, 16'h0000);
        chk("rst_done", 16'(tx_done), 16'h0000);

        // T1: plain 3-beat packet, tx_done on the third window cycle.
        load3("t1");
        frame3("t1");
        echk_step("t1_w1", 1'b0, 1'b0, 1'b0);
        echk_step("t1_w2", 1'b0, 1'b0, 1'b0);
        echk_step("t1_w3", 1'b0, 1'b1, 1'b0);
        chk("t1_idle_ready", 16'(s_ready), 16'h0001);
        chk("t1_idle_done", 16'(tx_done), 16'h0000);

        // T2: busy for 4 cycles on 0x22, plus busy+error while parity is stalled.
        load3("t2");
        step_chk("t2_hdr", 8'h0E, 1'b1, 1'b0, 1'b0);
        step_chk("t2_p0", 8'h11, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step_chk("t2_hold", 8'h22, 1'b1, 1'b1, 1'b0);
        end
        step_chk("t2_p1", 8'h22, 1'b1, 1'b0, 1'b0);
        step_chk("t2_p2", 8'h33, 1'b1, 1'b0, 1'b0);
        step_chk("t2_parhold", 8'h0E, 1'b0, 1'b1, 1'b1);
        step_chk("t2_par", 8'h0E, 1'b0, 1'b0, 1'b0);
        echk_step("t2_w1", 1'b0, 1'b0, 1'b0);
        echk_step("t2_w2", 1'b0, 1'b0, 1'b0);
        echk_step("t2_w3", 1'b0, 1'b1, 1'b0);
        chk("t2_errcnt", err_count, 16'h0000);

        // T3: error on every attempt: two replays, then tx_fail.
        load3("t3");
        for (int a = 0; a < 3; a++) begin
            frame3("t3");
            echk_step("t3_w1", 1'b1, 1'b0, (a == 2) ? 1'b1 : 1'b0);
            chk("t3_errcnt", err_count, 16'(a + 1));
        end
        chk("t3_idle_ready", 16'(s_ready), 16'h0001);
        chk("t3_idle_done", 16'(tx_done), 16'h0000);
        chk("t3_idle_fail", 16'(tx_fail), 16'h0000);

        // T5: 70 beats to dest 1; beat 63 truncates, 64..70 dropped.
        for (int i = 1; i <= 70; i++) begin
            put_beat("t5_beat", 8'(i), (i == 70) ? 1'b1 : 1'b0, (i == 1) ? 2'd1 : 2'd3,
                     (i == 63) ? 1'b1 : 1'b0);
        end
        step_chk("t5_hdr", 8'hFD, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 63; i++) begin
            step_chk("t5_pay", 8'(i), 1'b1, 1'b0, 1'b0);
        end
        // XOR of 1..63 is 0, so parity equals the header 0xFD.
        step_chk("t5_par", 8'hFD, 1'b0, 1'b0, 1'b0);
        echk_step("t5_w1", 1'b0, 1'b0, 1'b0);
        echk_step("t5_w2", 1'b0, 1'b0, 1'b0);
        echk_step("t5_w3", 1'b0, 1'b1, 1'b0);
        chk("t5_errcnt", err_count, 16'h0003);

        // T6: reset during payload, then a fresh 1-beat packet.
        load3("t6");
        step_chk("t6_hdr", 8'h0E, 1'b1, 1'b0, 1'b0);
        step_chk("t6_p0", 8'h11, 1'b1, 1'b0, 1'b0);
        do_reset();
        #1;
        chk("t6_rst_valid", 16'(pkt_valid), 16'h0000);
        chk("t6_rst_data", 16'(data_in), 16'h0000);
        chk("t6_rst_errcnt", err_count, 16'h0000);
        chk("t6_rst_ready", 16'(s_ready), 16'h0001);
        @(posedge clk); #1;
        put_beat("t6_new", 8'hA5, 1'b1, 2'd3, 1'b0);
        step_chk("t6_hdr2", 8'h07, 1'b1, 1'b0, 1'b0);
        step_chk("t6_pay2", 8'hA5, 1'b1, 1'b0, 1'b0);
        step_chk("t6_par2", 8'hA2, 1'b0, 1'b0, 1'b0);
        echk_step("t6_w1", 1'b0, 1'b0, 1'b0);
        echk_step("t6_w2", 1'b0, 1'b0, 1'b0);
        echk_step("t6_w3", 1'b0, 1'b1, 1'b0);

        // T4: error on the first attempt only: one replay then tx_done.
        load3("t4");
        frame3("t4a");
        echk_step("t4a_w1", 1'b1, 1'b0, 1'b0);
        chk("t4_errcnt_mid", err_count, 16'h0001);
        frame3("t4b");
        echk_step("t4b_w1", 1'b0, 1'b0, 1'b0);
        echk_step("t4b_w2", 1'b0, 1'b0, 1'b0);
        echk_step("t4b_w3", 1'b0, 1'b1, 1'b0);
        chk("t4_errcnt", err_count, 16'h0001);
        chk("t4_idle_ready", 16'(s_ready), 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
